hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Sequential multiply/divide unit with the HI/LO register pair.
- It is the consumer end of the 64-bit product/quotient path: it replaces single-cycle combinational MUL/DIV with a 32-iteration engine and a start/busy/done handshake.
- It holds HI/LO for MFHI/MFLO reads.
- It sits beside the ALU in the execute stage. The control unit stalls PC/writeback while busy is high.

Parameters:
- WIDTH, 32, operand width. Iteration count equals WIDTH. Only 32 is required to be supported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe. Sampled only when busy=0.
- op  in  3  operation code (see package constants).
- A  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
- B  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort the in-flight operation.
- busy  out  1  operation in progress. Registered.
- done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers cleared. Deasserting reset mid-operation leaves the unit IDLE; the aborted operation leaves no trace.
- States: IDLE, ITER, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch |A| and |B| (unsigned ops latch raw values).
  - Latch result signs: product sign = A[31]^B[31]; remainder sign = A[31].
  - Clear the 64-bit accumulator and cnt=0.
  - Go to ITER. busy=1 from the next cycle.
- IDLE, start=1, op=MTHI: hi<=A at that edge. op=MTLO: lo<=A at that edge. No busy, no done.
- IDLE, start=1 with any other op: no effect.
- ITER, multiply: one shift-add step per cycle (radix-2).
- ITER, divide: one restoring-divide step per cycle. Quotient bit shifts into the low half, partial remainder into the high half.
- ITER exit: cnt increments each cycle; after cnt=WIDTH-1 go to FIX.
- FIX:
  - Apply two's-complement sign correction to the 64-bit product, or to quotient and remainder independently.
  - Write hi/lo. Set done=1 for exactly one cycle. Return to IDLE.
- Latency: start edge = edge 0. hi/lo valid and done=1 after edge WIDTH+1 (edge 33). busy=1 for cycles following edges 0..32 and drops together with done rising.
- MULT/MULTU result: {hi,lo} = 64-bit product, signed or unsigned.
- DIV/DIVU result: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
- Divide by zero (B=0): no trap. Full latency still applies. lo=32'hFFFF_FFFF, hi=A (raw).
- Signed overflow (A=32'h8000_0000, B=32'hFFFF_FFFF, DIV): lo=32'h8000_0000, hi=0.
- start while busy=1: ignored, never queued. The control unit must hold the instruction.
- flush=1: in any state, go to IDLE at that edge with busy=0 and done=0; hi/lo are not modified. If flush and start arrive in the same IDLE cycle, flush wins (request dropped).
- hi/lo change only in FIX, on MTHI/MTLO, or on reset. Reads are combinational from the registers.

Decomposition:
- Add to control_encode.vh: MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
- Add state encodings MD_IDLE, MD_ITER, MD_FIX.
- One sub-module is natural: muldiv_step. It is combinational, containing one add/shift step and one subtract/restore step, selected by an is_div input. The top module holds the FSM, counter, sign logic and HI/LO.

Test Plan:
- MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> after 33 cycles hi=32'hFFFF_FFFE, lo=32'h0000_0001; done pulses exactly one cycle; busy high 33 cycles.
- MULT A=-7 (32'hFFFF_FFF9), B=3 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB (-21).
- DIV A=-7, B=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU A=100, B=7 -> lo=14, hi=2.
- DIV A=5, B=0 -> lo=32'hFFFF_FFFF, hi=5. DIV A=32'h8000_0000, B=-1 -> lo=32'h8000_0000, hi=0.
- Start MULT, assert a second start at cycle 5 (ignored), then flush at cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values. MTHI 32'hDEAD_BEEF when idle -> hi updates at that edge.
- Drop rst_n asynchronously mid-DIV at cycle 17 -> hi, lo, busy, done all 0 immediately, before the next clock edge. The next MULT after release completes normally.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared op codes, FSM states and latched operation context for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    localparam int unsigned MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // neg_lo negates the product (multiply) or the quotient (divide); neg_hi the remainder.
    typedef struct packed {
        logic is_div;
        logic neg_lo;
        logic neg_hi;
    } md_ctx_t;

endpackage

// File: rtl/hilo_muldiv_step.sv
// One iteration of the engine: MSB-first shift-add multiply or restoring divide step.
module hilo_muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic                 a_msb,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_next_c
);

    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    always_comb begin
        mul_next = {acc[2*WIDTH-2:0], 1'b0} + (a_msb ? {{WIDTH{1'b0}}, b} : '0);
        // Partial remainder lives in the high half; the next dividend bit comes from a_msb.
        shifted  = {acc[2*WIDTH-1:WIDTH], a_msb};
        diff     = shifted - {1'b0, b};
        if (!is_div) begin
            acc_next_c = mul_next;
        end else if (!diff[WIDTH]) begin
            acc_next_c = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next_c = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Sequential 32-iteration MULT/DIV engine with HI/LO register pair and start/busy/done handshake.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MD_OP_W-1:0]   op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_e           state;
    logic [CNT_W-1:0]    cnt;
    logic [2*WIDTH-1:0]  acc;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    md_ctx_t             ctx;

    logic                is_arith_c;
    logic                is_div_op_c;
    logic                is_signed_c;
    logic                b_zero_c;
    logic [WIDTH-1:0]    a_abs_c;
    logic [WIDTH-1:0]    b_abs_c;
    md_ctx_t             ctx_c;
    logic [2*WIDTH-1:0]  acc_next_c;
    logic [2*WIDTH-1:0]  prod_fix_c;
    logic [WIDTH-1:0]    quo_fix_c;
    logic [WIDTH-1:0]    rem_fix_c;

    // Request decode, operand magnitudes and result signs captured at start.
    always_comb begin
        is_div_op_c  = (op == MD_DIV) || (op == MD_DIVU);
        is_signed_c  = (op == MD_MULT) || (op == MD_DIV);
        is_arith_c   = (op == MD_MULT) || (op == MD_MULTU) || is_div_op_c;
        b_zero_c     = (B == '0);
        a_abs_c      = (is_signed_c && A[WIDTH-1]) ? -A : A;
        b_abs_c      = (is_signed_c && B[WIDTH-1]) ? -B : B;
        ctx_c        = '0;
        ctx_c.is_div = is_div_op_c;
        // A zero divisor must leave the all-ones quotient un-negated.
        ctx_c.neg_lo = is_signed_c && (A[WIDTH-1] ^ B[WIDTH-1]) && !(is_div_op_c && b_zero_c);
        ctx_c.neg_hi = is_signed_c && A[WIDTH-1];
    end

    always_comb begin
        prod_fix_c = ctx.neg_lo ? -acc : acc;
        quo_fix_c  = ctx.neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix_c  = ctx.neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    hilo_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (ctx.is_div),
        .acc        (acc),
        .a_msb      (a_reg[WIDTH-1]),
        .b          (b_reg),
        .acc_next_c (acc_next_c)
    );

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
            acc   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            ctx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start && is_arith_c) begin
                        a_reg <= a_abs_c;
                        b_reg <= b_abs_c;
                        ctx   <= ctx_c;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MD_ITER;
                    end else if (start && op == MD_MTHI) begin
                        hi <= A;
                    end else if (start && op == MD_MTLO) begin
                        lo <= A;
                    end
                end
                MD_ITER: begin
                    acc   <= acc_next_c;
                    a_reg <= {a_reg[WIDTH-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    if (ctx.is_div) begin
                        hi <= rem_fix_c;
                        lo <= quo_fix_c;
                    end else begin
                        hi <= prod_fix_c[2*WIDTH-1:WIDTH];
                        lo <= prod_fix_c[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed bench for hilo_muldiv against an arithmetic HI/LO reference model.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Reference: {hi,lo} after an operation, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = cur;
        case (o)
            MD_MULT:  res = 64'(sa * sb);
            MD_MULTU: res = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            MD_MTHI:  res = {a, cur[31:0]};
            MD_MTLO:  res = {cur[63:32], a};
            default:  res = cur;
        endcase
        return res;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_arith(input string tag, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] b);
        int lat;
        int busy_cnt;
        logic [63:0] e;
        e = ref_model(o, a, b, {exp_hi, exp_lo});
        issue(o, a, b);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        {exp_hi, exp_lo} = e;
        chk({tag, "_lat"}, 64'(lat), 64'd33);
        chk({tag, "_busycyc"}, 64'(busy_cnt), 64'd33);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, e);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_move(input string tag, input logic [2:0] o, input logic [31:0] a);
        {exp_hi, exp_lo} = ref_model(o, a, $urandom, {exp_hi, exp_lo});
        issue(o, a, $urandom);
        chk({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        chk({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int ndone;
        int nbusy;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = '0;
        A     = '0;
        B     = '0;
        exp_hi = '0;
        exp_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_arith("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_arith("mult_neg", MD_MULT, 32'hFFFF_FFF9, 32'd3);
        chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_arith("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_arith("divu", MD_DIVU, 32'd100, 32'd7);
        chk("divu_const", {hi, lo}, {32'd2, 32'd14});
        run_arith("div_zero", MD_DIV, 32'd5, 32'd0);
        chk("div_zero_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run_arith("div_neg_zero", MD_DIV, 32'hFFFF_FFF9, 32'd0);
        run_arith("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});

        run_move("mthi", MD_MTHI, 32'hDEAD_BEEF);
        chk("mthi_const", 64'(hi), 64'hDEAD_BEEF);

        // Flush mid-MULT with an ignored second start in between.
        issue(MD_MULT, 32'h1234_5678, 32'h0000_0ABC);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op    = MD_MTLO;
        A     = 32'hCAFE_F00D;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_ignored", {hi, lo, 63'd0, busy}, {exp_hi, exp_lo, 64'd1});
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy_done", {62'd0, busy, done}, 64'd0);
        chk("flush_hilo", {hi, lo}, {exp_hi, exp_lo});
        ndone = 0;
        nbusy = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("flush_no_done", 64'(ndone), 64'd0);
        chk("flush_stays_idle", 64'(nbusy), 64'd0);
        chk("flush_hilo_after", {hi, lo}, {exp_hi, exp_lo});

        // Flush and MTLO in the same idle cycle: flush wins.
        @(negedge clk);
        op    = MD_MTLO;
        A     = 32'h5555_AAAA;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_beats_mtlo", {hi, lo}, {exp_hi, exp_lo});

        // Asynchronous reset mid-DIV.
        run_move("mtlo_pre_rst", MD_MTLO, 32'h0BAD_F00D);
        issue(MD_DIV, 32'h7654_3210, 32'd9);
        repeat (16) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        chk("async_rst_busy_done", {62'd0, busy, done}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_arith("mult_after_rst", MD_MULT, 32'h8000_0000, 32'h8000_0000);

        // Randomized mix of all op codes.
        for (int i = 0; i < 50; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            if (o <= MD_DIVU) begin
                run_arith($sformatf("rnd%0d_op%0d", i, o), o, a, b);
            end else if (o == MD_MTHI || o == MD_MTLO) begin
                run_move($sformatf("rnd%0d_mv%0d", i, o), o, a);
            end else begin
                issue(o, a, b);
                chk($sformatf("rnd%0d_nop", i), {hi, lo, 63'd0, busy}, {exp_hi, exp_lo, 64'd0});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
